// File: rtl/csi2_pkg.sv
// CSI-2 shared types: data types, header layout, parser states.
// Helpers: byte-enable mask for the final payload word.
package csi2_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } csi2_hdr_t;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DISCARD
  } state_t;

  // Bytes valid in a word given bytes remaining.
  function automatic logic [3:0] be_mask(
    input logic [15:0] rem
  );
    logic [3:0] m;
    m = 4'hF;
    unique case (1'b1)
      (rem == 16'd1): m = 4'h1;
      (rem == 16'd2): m = 4'h3;
      (rem == 16'd3): m = 4'h7;
      default:        m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/csi2_pkt_to_video.sv
// CSI-2 packet stream to pixel-clock video words.
// Ports: clk_i/rst_i; pkt_* in (val/ready); video_* out;
// trunc_err_o pulse on sop mid-payload.
// Option: CSI2_VC_FILTER_EN accepts only VC_ID headers.
module csi2_pkt_to_video
  import csi2_pkg::*;
#(
  parameter logic [5:0] DATA_TYPE = DT_RAW10,
  parameter logic [1:0] VC_ID     = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pkt_data_i,
  input  logic        pkt_val_i,
  input  logic        pkt_sop_i,
  output logic        pkt_ready_o,
  output logic [31:0] video_data_o,
  output logic [3:0]  video_be_o,
  output logic        video_data_val_o,
  output logic        video_eol_o,
  output logic        video_frame_start_o,
  input  logic        video_proc_ready_i,
  output logic        trunc_err_o
);

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        fs_q, fs_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        val_q, val_d;
  logic        eol_q, eol_d;
  logic        fso_q, fso_d;
  logic        trunc_q, trunc_d;

  csi2_hdr_t   hdr;
  logic        acc;
  logic        vc_ok;
  logic        short_pkt;
  logic        last;
  logic        emit;

  assign hdr = csi2_hdr_t'(pkt_data_i);

`ifdef CSI2_VC_FILTER_EN
  logic ecc_unused;
  assign ecc_unused = ^hdr.ecc;
  assign vc_ok = (hdr.vc == VC_ID);
`else
  logic vc_unused;
  assign vc_unused = ^{hdr.ecc, hdr.vc, VC_ID};
  assign vc_ok = 1'b1;
`endif

  assign pkt_ready_o = !val_q || video_proc_ready_i;
  assign acc         = pkt_val_i && pkt_ready_o;
  assign short_pkt   = (hdr.dt[5:4] == 2'b00);
  assign last        = (rem_q <= 16'd4);
  assign emit        = acc && !pkt_sop_i && (state_q == PAYLOAD);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fs_d    = fs_q;
    trunc_d = acc && pkt_sop_i && (state_q != HDR);
    if (acc) begin
      if (pkt_sop_i) begin
        // Any sop is a header, even one that cuts a payload short.
        state_d = HDR;
        if (short_pkt) begin
          if (hdr.dt == DT_FS && vc_ok) fs_d = 1'b1;
        end else if (hdr.wc != 16'd0) begin
          rem_d   = hdr.wc;
          state_d = (vc_ok && hdr.dt == DATA_TYPE) ? PAYLOAD : DISCARD;
        end
      end else if (state_q != HDR) begin
        rem_d = last ? 16'd0 : rem_q - 16'd4;
        if (last) state_d = HDR;
        if (state_q == PAYLOAD) fs_d = 1'b0;
      end
    end
  end

  always_comb begin
    data_d = data_q;
    be_d   = be_q;
    val_d  = val_q;
    eol_d  = eol_q;
    fso_d  = fso_q;
    if (emit) begin
      data_d = pkt_data_i;
      be_d   = be_mask(rem_q);
      val_d  = 1'b1;
      eol_d  = last;
      fso_d  = fs_q;
    end else if (video_proc_ready_i) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HDR;
      rem_q   <= 16'd0;
      fs_q    <= 1'b0;
      data_q  <= 32'd0;
      be_q    <= 4'd0;
      val_q   <= 1'b0;
      eol_q   <= 1'b0;
      fso_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fs_q    <= fs_d;
      data_q  <= data_d;
      be_q    <= be_d;
      val_q   <= val_d;
      eol_q   <= eol_d;
      fso_q   <= fso_d;
      trunc_q <= trunc_d;
    end
  end

  assign video_data_o        = data_q;
  assign video_be_o          = be_q;
  assign video_data_val_o    = val_q;
  assign video_eol_o         = eol_q;
  assign video_frame_start_o = fso_q;
  assign trunc_err_o         = trunc_q;

endmodule

// File: tb/tb_csi2_pkt_to_video.sv
// Directed bench for csi2_pkt_to_video.
// Checks framing, byte enables, filtering, stalls.
module tb_csi2_pkt_to_video;

`ifdef CSI2_VC_FILTER_EN
  localparam logic [1:0] VCID = 2'd1;
`else
  localparam logic [1:0] VCID = 2'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_data = 32'd0;
  logic        pkt_val = 1'b0;
  logic        pkt_sop = 1'b0;
  logic        pkt_ready;
  logic [31:0] vdata;
  logic [3:0]  vbe;
  logic        vval;
  logic        veol;
  logic        vfs;
  logic        vrdy = 1'b1;
  logic        trunc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  csi2_pkt_to_video #(
    .DATA_TYPE(6'h2B),
    .VC_ID(VCID)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pkt_data_i(pkt_data),
    .pkt_val_i(pkt_val),
    .pkt_sop_i(pkt_sop),
    .pkt_ready_o(pkt_ready),
    .video_data_o(vdata),
    .video_be_o(vbe),
    .video_data_val_o(vval),
    .video_eol_o(veol),
    .video_frame_start_o(vfs),
    .video_proc_ready_i(vrdy),
    .trunc_err_o(trunc)
  );

  function automatic logic [31:0] hdr(
    input logic [1:0] vc, input logic [5:0] dt,
    input logic [15:0] wc
  );
    return {8'h00, wc, vc, dt};
  endfunction

  task automatic chk(
    input string tag, input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // Expected full output word: val,eol,fs,be,data.
  task automatic chko(
    input string tag, input logic e,
    input logic f, input logic [3:0] be,
    input logic [31:0] d
  );
    chk(tag, {vval, veol, vfs, vbe, vdata},
        {1'b1, e, f, be, d});
  endtask

  task automatic step(input logic [31:0] d, input logic s);
    @(negedge clk);
    pkt_data = d;
    pkt_val  = 1'b1;
    pkt_sop  = s;
    @(posedge clk);
    #1;
    pkt_val  = 1'b0;
    pkt_sop  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    pkt_val = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, errs;
    logic rdy_n, stall;
    logic [31:0] hold;

    // Reset state
    #2;
    chk("rst_val", vval, 0);
    chk("rst_ready", pkt_ready, 1);
    chk("rst_misc", {vdata, vbe, veol, vfs, trunc}, 0);
    @(negedge clk);
    rst = 1'b0;

    // FS + RAW10 WC=16
    step(hdr(2'd0, 6'h00, 16'd0), 1);
    chk("fs_noout", vval, 0);
    step(hdr(2'd0, 6'h2B, 16'd16), 1);
    chk("hdr_noout", vval, 0);
    step(32'hA0A0A0A0, 0);
    chko("l1w0", 0, 1, 4'hF, 32'hA0A0A0A0);
    step(32'hA1A1A1A1, 0);
    chko("l1w1", 0, 0, 4'hF, 32'hA1A1A1A1);
    step(32'hA2A2A2A2, 0);
    chko("l1w2", 0, 0, 4'hF, 32'hA2A2A2A2);
    step(32'hA3A3A3A3, 0);
    chko("l1w3", 1, 0, 4'hF, 32'hA3A3A3A3);
    idle();
    chk("l1_drain", vval, 0);

    // WC=10 -> F,F,3
    step(hdr(2'd0, 6'h2B, 16'd10), 1);
    step(32'hB0000000, 0);
    chko("l2w0", 0, 0, 4'hF, 32'hB0000000);
    step(32'hB1000000, 0);
    chko("l2w1", 0, 0, 4'hF, 32'hB1000000);
    step(32'h0000B2B2, 0);
    chko("l2w2", 1, 0, 4'h3, 32'h0000B2B2);

    // RAW8 discarded, RAW10 follows
    step(hdr(2'd0, 6'h2A, 16'd8), 1);
    chk("raw8_h", vval, 0);
    step(32'hDEAD0001, 0);
    chk("raw8_w0", vval, 0);
    step(32'hDEAD0002, 0);
    chk("raw8_w1", vval, 0);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    step(32'hC0C0C0C0, 0);
    chko("after8", 1, 0, 4'hF, 32'hC0C0C0C0);

    // Backpressure over 64 bytes
    step(hdr(2'd0, 6'h2B, 16'd64), 1);
    sent = 0;
    got  = 0;
    errs = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge clk);
      rdy_n    = (c % 2 == 0);
      vrdy     = rdy_n;
      pkt_val  = (sent < 16);
      pkt_sop  = 1'b0;
      pkt_data = 32'h5000_0000 + sent;
      #1;
      chk("bp_ready", pkt_ready, !vval || rdy_n);
      if (vval && rdy_n) begin
        if (vdata !== 32'h5000_0000 + got) errs++;
        if (vbe !== 4'hF) errs++;
        if (veol !== (got == 15)) errs++;
        got++;
      end
      if (pkt_val && pkt_ready) sent++;
      stall = vval && !rdy_n;
      hold  = vdata;
      @(posedge clk);
      #1;
      if (stall && (vdata !== hold || vval !== 1'b1))
        errs++;
    end
    pkt_val = 1'b0;
    vrdy    = 1'b1;
    chk("bp_count", got, 16);
    chk("bp_errs", errs, 0);
    idle();
    chk("bp_drain", vval, 0);

    // Truncation
    step(hdr(2'd0, 6'h2B, 16'd16), 1);
    step(32'hD0D0D0D0, 0);
    chko("tr_w0", 0, 0, 4'hF, 32'hD0D0D0D0);
    step(32'hD1D1D1D1, 0);
    chko("tr_w1", 0, 0, 4'hF, 32'hD1D1D1D1);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    chk("tr_pulse", trunc, 1);
    chk("tr_noout", vval, 0);
    step(32'hE0E0E0E0, 0);
    chk("tr_clr", trunc, 0);
    chko("tr_new", 1, 0, 4'hF, 32'hE0E0E0E0);

    // FS during handshake of previous eol
    step(hdr(2'd0, 6'h00, 16'd0), 1);
    chk("fs_hs", vval, 0);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    step(32'hF0F0F0F0, 0);
    chko("fs_next", 1, 1, 4'hF, 32'hF0F0F0F0);

    // Byte enable boundaries
    step(hdr(2'd0, 6'h2B, 16'd5), 1);
    step(32'h11111111, 0);
    chko("wc5_w0", 0, 0, 4'hF, 32'h11111111);
    step(32'h00000022, 0);
    chko("wc5_w1", 1, 0, 4'h1, 32'h00000022);
    step(hdr(2'd0, 6'h2B, 16'd3), 1);
    step(32'h00333333, 0);
    chko("wc3", 1, 0, 4'h7, 32'h00333333);
    step(hdr(2'd0, 6'h2B, 16'd1), 1);
    step(32'h00000044, 0);
    chko("wc1", 1, 0, 4'h1, 32'h00000044);

    // Ignored headers and dropped words
    step(hdr(2'd0, 6'h02, 16'd0), 1);
    chk("ls_ign", vval, 0);
    step(hdr(2'd0, 6'h2B, 16'd0), 1);
    chk("wc0_ign", vval, 0);
    step(32'h99999999, 0);
    chk("nonsop", vval, 0);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    step(32'h77777777, 0);
    chko("post_ign", 1, 0, 4'hF, 32'h77777777);

    // Double FS sets fs once
    step(hdr(2'd0, 6'h00, 16'd0), 1);
    step(hdr(2'd0, 6'h00, 16'd0), 1);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    step(32'h12121212, 0);
    chko("dfs_1", 1, 1, 4'hF, 32'h12121212);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    step(32'h34343434, 0);
    chko("dfs_2", 1, 0, 4'hF, 32'h34343434);

    // Reset mid-packet
    step(hdr(2'd0, 6'h2B, 16'd16), 1);
    step(32'h56565656, 0);
    chko("rm_w0", 0, 0, 4'hF, 32'h56565656);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rm_val", vval, 0);
    chk("rm_ready", pkt_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step(32'h78787878, 0);
    chk("rm_drop", vval, 0);

`ifdef CSI2_VC_FILTER_EN
    step(hdr(2'd0, 6'h00, 16'd0), 1);
    step(hdr(2'd0, 6'h2B, 16'd4), 1);
    step(32'hCC000000, 0);
    chk("vc0_drop", vval, 0);
    step(hdr(2'd1, 6'h00, 16'd0), 1);
    step(hdr(2'd1, 6'h2B, 16'd4), 1);
    step(32'hCC111111, 0);
    chko("vc1_line", 1, 1, 4'hF, 32'hCC111111);
`endif

    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/csi2_pkt_to_video.md
Name: csi2_pkt_to_video

Overview:
- Converts the CSI-2 packet stream into the pixel-clock video stream consumed by csi2_stat_acc and the video processing chain.
- Input is the packet stream after CDC and CRC footer stripping: one header word marked with sop, followed by payload words.
- Parses the header, filters by data type, and emits payload words with byte enables and an end-of-line flag.
- Marks the first pixel word of each frame with frame_start.

Parameters:
- DATA_TYPE, 6'h2B, long-packet data type forwarded (default RAW10); all other long packets are discarded.
- VC_ID, 2'd0, virtual channel accepted; used only when CSI2_VC_FILTER_EN is defined.

Ports:
- clk_i  input  1  pixel clock.
- rst_i  input  1  asynchronous active-high reset.
- pkt_data_i  input  32  packet word. On a header word: [7:6] VC, [5:0] DT, [23:8] word count (WC) in bytes, [31:24] ECC (ignored).
- pkt_val_i  input  1  pkt_data_i is valid.
- pkt_sop_i  input  1  current word is a packet header.
- pkt_ready_o  output  1  word accepted when pkt_val_i && pkt_ready_o.
- video_data_o  output  32  payload bytes, little-endian (byte 0 = [7:0]).
- video_be_o  output  4  byte enables; 4'hF except on the last word of a line.
- video_data_val_o  output  1  output word valid.
- video_eol_o  output  1  last word of the line.
- video_frame_start_o  output  1  first word after a Frame Start short packet.
- video_proc_ready_i  input  1  downstream ready.
- trunc_err_o  output  1  one-cycle pulse: a sop arrived before the current payload completed.

Behaviour:
- Reset values: all outputs 0, except pkt_ready_o = 1. State = HDR, byte counter = 0, fs_pending = 0.
- Output stage:
  - Single register stage; latency is 1 cycle from input acceptance to video_data_val_o.
  - pkt_ready_o = !video_data_val_o || video_proc_ready_i, purely combinational from the output register state.
  - Output holds stable while video_data_val_o && !video_proc_ready_i.
  - video_data_val_o clears after a handshake if no new word is loaded.
- State HDR (accepts only words with sop):
  - DT 0x00 (Frame Start): set fs_pending; stay in HDR.
  - DT 0x01–0x0F (other short packets): ignored; stay in HDR.
  - DT == DATA_TYPE and WC != 0: load rem = WC, go to PAYLOAD.
  - Any other long packet with WC != 0: load rem = WC, go to DISCARD.
  - Long packet with WC == 0: ignored; stay in HDR.
  - Non-sop word: dropped; stay in HDR.
- State PAYLOAD, per accepted word:
  - Emit the word with video_be_o = mask(min(rem, 4)): 1 → 4'h1, 2 → 4'h3, 3 → 4'h7, ≥4 → 4'hF.
  - video_eol_o = (rem <= 4); rem decrements by 4.
  - When rem <= 4: go to HDR.
  - video_frame_start_o = fs_pending on the emitted word; fs_pending clears when that word is loaded.
- State DISCARD: same counting as PAYLOAD, but nothing is emitted; when rem <= 4, go to HDR.
- Truncated packet: sop while in PAYLOAD or DISCARD.
  - Pulse trunc_err_o.
  - Process the word as a header, exactly as in HDR.
  - The partial line is not given an eol.
- A second Frame Start while fs_pending is set: no change.
- Frame Start in the same cycle as a handshake: fs_pending applies to the next line's first word.
- rem is 16 bits with no wrap; WC = 16'hFFFF produces 16384 words.
- Reset mid-packet: immediate return to reset values; the packet in flight is lost.

Optional Feature:
- CSI2_VC_FILTER_EN defined:
  - A header is acted on only if VC == VC_ID.
  - Frame Start on another VC does not set fs_pending.
  - Long packets on another VC go to DISCARD.
- CSI2_VC_FILTER_EN undefined: VC bits are ignored; all VCs are merged.

Decomposition:
- Package csi2_pkg holds:
  - DT constants: DT_FS = 6'h00, DT_FE = 6'h01, DT_LS = 6'h02, DT_LE = 6'h03, DT_RAW8 = 6'h2A, DT_RAW10 = 6'h2B.
  - Typedef csi2_hdr_t (packed: ecc, wc, vc, dt).
  - State enum {HDR, PAYLOAD, DISCARD}.
- Sub-module: none required. The byte-enable mask is a function in csi2_pkg.

Test Plan:
- FS, then a RAW10 header with WC = 16, then 4 words, with ready = 1 → 4 output words:
  - first has frame_start = 1;
  - last has eol = 1 and be = 4'hF;
  - 1-cycle latency.
- Header WC = 10, 3 words → be = F, F, 3; eol only on the third word; frame_start = 0 (no FS).
- Header DT = 6'h2A (RAW8) with WC = 8, then a RAW10 line → RAW8 words are not output; the RAW10 line is output normally.
- Backpressure: video_proc_ready_i toggles 1010… over a 64-byte line → pkt_ready_o follows the ready rule; 16 words out with no loss, no duplication, and stable data while stalled.
- A sop arrives after 2 of 4 payload words of WC = 16, carrying a new WC = 4 header → trunc_err_o pulses for 1 cycle; 2 words without eol, then 1 word with eol.
- With CSI2_VC_FILTER_EN defined and VC_ID = 1: FS plus a line on VC 0, then FS plus a line on VC 1 → only the VC 1 line is output, with frame_start = 1 on its first word.
